xif_mem_bridge: RTL



---
 rtl/coproc_pkg.sv | 37 +++
 rtl/xif_mem_bridge.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/coproc_pkg.sv
// Shared types and helpers for the coprocessor eXtension-interface memory path.
// Holds the bridge FSM state encoding, the access-size encoding and the request legality check.
// No ports; imported by xif_mem_bridge.
package coproc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RESP   = 2'd2,
        RESULT = 2'd3
    } xif_mem_state_e;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'd0,
        SIZE_HALF = 3'd1,
        SIZE_WORD = 3'd2
    } mem_size_e;

    // A request is legal when its size is byte/half/word, the address is
    // naturally aligned for that size, and it falls inside [lo, hi].
    function automatic logic mem_req_legal(
        input logic [31:0] addr,
        input logic [2:0]  size,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        logic aligned;
        case (size)
            SIZE_BYTE: aligned = 1'b1;
            SIZE_HALF: aligned = ~addr[0];
            SIZE_WORD: aligned = (addr[1:0] == 2'b00);
            default:   aligned = 1'b0;
        endcase
        return aligned && (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/xif_mem_bridge.sv
// Bridges the eXtension-interface memory request channel onto one OBI data-master port.
// Latency: zero-wait bus gives accept@N, obi_req@N+1, rvalid@N+2, result@N+3; illegal requests complete at N+1.
// Backpressure: single outstanding transaction; mem_ready_o only high in IDLE; results are a one-cycle pulse with no back-pressure.
// Ports: mem_* request channel in, commit_* kill strobe in, mem_result_* pulse out, obi_* data-master port.
module xif_mem_bridge
    import coproc_pkg::*;
#(
    parameter int          X_ID_WIDTH     = 4,
    parameter int          X_MEM_WIDTH    = 32,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ADDR_LO        = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI        = 32'hFFFF_FFFF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   mem_valid_i,
    output logic                   mem_ready_o,
    input  logic [X_ID_WIDTH-1:0]  mem_id_i,
    input  logic [31:0]            mem_addr_i,
    input  logic                   mem_we_i,
    input  logic [2:0]             mem_size_i,
    input  logic [3:0]             mem_be_i,
    input  logic [X_MEM_WIDTH-1:0] mem_wdata_i,

    input  logic                   commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]  commit_id_i,
    input  logic                   commit_kill_i,

    output logic                   mem_result_valid_o,
    output logic [X_ID_WIDTH-1:0]  mem_result_id_o,
    output logic [X_MEM_WIDTH-1:0] mem_result_rdata_o,
    output logic                   mem_result_err_o,
    output logic                   mem_result_dbg_o,

    output logic                   obi_req_o,
    input  logic                   obi_gnt_i,
    output logic [31:0]            obi_addr_o,
    output logic                   obi_we_o,
    output logic [3:0]             obi_be_o,
    output logic [X_MEM_WIDTH-1:0] obi_wdata_o,
    input  logic                   obi_rvalid_i,
    input  logic [X_MEM_WIDTH-1:0] obi_rdata_i,
    input  logic                   obi_err_i
);

    xif_mem_state_e         state_q;
    logic [X_ID_WIDTH-1:0]  id_q;
    logic [X_MEM_WIDTH-1:0] rdata_q;
    logic                   err_q;
    logic                   res_vld_q;
    logic                   obi_req_q;
    logic [31:0]            obi_addr_q;
    logic                   obi_we_q;
    logic [3:0]             obi_be_q;
    logic [X_MEM_WIDTH-1:0] obi_wdata_q;
    logic [15:0]            tmo_cnt_q;

    logic req_legal;
    logic kill_hit;
    logic tmo_hit;

    assign req_legal = mem_req_legal(mem_addr_i, mem_size_i, ADDR_LO, ADDR_HI);
    assign kill_hit  = commit_valid_i & commit_kill_i & (commit_id_i == id_q);

    // The counter holds k in the k-th cycle after obi_req rises, so the
    // timeout fires on the edge that ends cycle TIMEOUT_CYCLES-1 and the
    // error result appears exactly TIMEOUT_CYCLES cycles after the request.
    assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            id_q        <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            res_vld_q   <= 1'b0;
            obi_req_q   <= 1'b0;
            obi_addr_q  <= '0;
            obi_we_q    <= 1'b0;
            obi_be_q    <= '0;
            obi_wdata_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            // Result is a single-cycle pulse unless a branch below raises it.
            res_vld_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    // Stray rvalid (after a timeout or reset) is ignored here.
                    if (mem_valid_i) begin
                        id_q <= mem_id_i;
                        if (req_legal) begin
                            state_q     <= REQ;
                            obi_req_q   <= 1'b1;
                            obi_addr_q  <= {mem_addr_i[31:2], 2'b00};
                            obi_we_q    <= mem_we_i;
                            obi_be_q    <= mem_be_i;
                            obi_wdata_q <= mem_wdata_i;
                            tmo_cnt_q   <= '0;
                        end else begin
                            // Illegal requests never touch the bus.
                            state_q   <= RESULT;
                            res_vld_q <= 1'b1;
                            rdata_q   <= '0;
                            err_q     <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    if (kill_hit && !obi_gnt_i) begin
                        // Killed before the bus took it: drop silently.
                        state_q   <= IDLE;
                        obi_req_q <= 1'b0;
                    end else if (tmo_hit) begin
                        state_q   <= RESULT;
                        obi_req_q <= 1'b0;
                        res_vld_q <= 1'b1;
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                    end else if (obi_gnt_i) begin
                        state_q   <= RESP;
                        obi_req_q <= 1'b0;
                    end
                end

                RESP: begin
                    // Once granted the access is on the bus, so kills are ignored.
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    if (obi_rvalid_i) begin
                        state_q   <= RESULT;
                        res_vld_q <= 1'b1;
                        rdata_q   <= obi_we_q ? '0 : obi_rdata_i;
                        err_q     <= obi_err_i;
                    end else if (tmo_hit) begin
                        state_q   <= RESULT;
                        res_vld_q <= 1'b1;
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                    end
                end

                RESULT: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Ready is gated by reset so the requester sees 0 while reset is held.
    assign mem_ready_o        = (state_q == IDLE) & rst_ni;

    assign mem_result_valid_o = res_vld_q;
    assign mem_result_id_o    = id_q;
    assign mem_result_rdata_o = rdata_q;
    assign mem_result_err_o   = err_q;
    assign mem_result_dbg_o   = 1'b0;

    assign obi_req_o          = obi_req_q;
    assign obi_addr_o         = obi_addr_q;
    assign obi_we_o           = obi_we_q;
    assign obi_be_o           = obi_be_q;
    assign obi_wdata_o        = obi_wdata_q;

endmodule
